// File: rtl/ball_motion_sequencer.sv
// Per-frame position/velocity sequencer for the metaball renderer; one shared adder updates one axis per cycle.
// Optional velocity saturation to [-VMAX, +VMAX] is enabled by defining BALL_SEQ_VCLAMP_EN.
module ball_motion_sequencer #(
  parameter int N_BALLS       = 4,
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BALL_SIZE     = 128,
  parameter int VMAX          = 31
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       v_sync,
  input  logic       freeze,
  input  logic [2:0] sel,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] UPD_X = 2'd1;
  localparam logic [1:0] UPD_Y = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [11:0] CX = 12'(((SCREEN_WIDTH - BALL_SIZE) / 2) << 2);
  localparam logic [11:0] CY = 12'(((SCREEN_HEIGHT - BALL_SIZE) / 2) << 2);
  localparam logic [2:0]  K_LAST = 3'(N_BALLS - 1);

  logic [1:0]  state;
  logic [2:0]  k;
  logic        vs_q;
  logic        start;
  logic [11:0] pos_x [N_BALLS];
  logic [11:0] pos_y [N_BALLS];
  logic [9:0]  vel_x [N_BALLS];
  logic [9:0]  vel_y [N_BALLS];

  logic [11:0] cur_pos;
  logic [9:0]  cur_vel;
  logic [11:0] next_pos;
  logic [11:0] center;
  logic        toward;
  logic [9:0]  vel_new;

  assign start      = vs_q && !v_sync && (state == IDLE) && !freeze;
  assign busy       = (state == UPD_X) || (state == UPD_Y);
  assign frame_done = (state == DONE);

  // Shared datapath: select the axis of ball k being updated this cycle.
  always_comb begin
    cur_pos = '0;
    cur_vel = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (k == 3'(i)) begin
        cur_pos = (state == UPD_Y) ? pos_y[i] : pos_x[i];
        cur_vel = (state == UPD_Y) ? vel_y[i] : vel_x[i];
      end
    end
  end

  assign center   = (state == UPD_Y) ? CY : CX;
  assign next_pos = cur_pos + {{2{cur_vel[9]}}, cur_vel};
  assign toward   = next_pos < center;

`ifdef BALL_SEQ_VCLAMP_EN
  localparam logic signed [10:0] VMAX_S = 11'(VMAX);
  logic signed [10:0] vel_step;
  logic signed [10:0] vel_sum;

  always_comb begin
    vel_step = toward ? 11'sd1 : -11'sd1;
    vel_sum  = $signed({cur_vel[9], cur_vel}) + vel_step;
    if (vel_sum > VMAX_S) begin
      vel_new = VMAX_S[9:0];
    end else if (vel_sum < -VMAX_S) begin
      vel_new = 10'(-VMAX_S);
    end else begin
      vel_new = vel_sum[9:0];
    end
  end
`else
  localparam int unused_vmax = VMAX;
  assign vel_new = cur_vel + (toward ? 10'd1 : 10'h3FF);
`endif

  // Sequencer and per-ball state; reset reloads the evenly spread start grid.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      vs_q  <= 1'b1;
      for (int i = 0; i < N_BALLS; i++) begin
        pos_x[i] <= 12'(((SCREEN_WIDTH - BALL_SIZE) * (i + 1) / (N_BALLS + 1)) << 2);
        pos_y[i] <= 12'(((SCREEN_HEIGHT - BALL_SIZE) * (N_BALLS - i) / (N_BALLS + 1)) << 2);
        vel_x[i] <= '0;
        vel_y[i] <= '0;
      end
    end else begin
      vs_q <= v_sync;
      case (state)
        IDLE: begin
          if (start) begin
            state <= UPD_X;
            k     <= '0;
          end
        end
        UPD_X: state <= UPD_Y;
        UPD_Y: begin
          if (k < K_LAST) begin
            state <= UPD_X;
            k     <= k + 3'd1;
          end else begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < N_BALLS; i++) begin
        if (k == 3'(i) && state == UPD_X) begin
          pos_x[i] <= next_pos;
          vel_x[i] <= vel_new;
        end
        if (k == 3'(i) && state == UPD_Y) begin
          pos_y[i] <= next_pos;
          vel_y[i] <= vel_new;
        end
      end
    end
  end

  // Pixel-path read port; unpopulated ball slots read as zero.
  always_comb begin
    ball_x = '0;
    ball_y = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (sel == 3'(i)) begin
        ball_x = pos_x[i][11:2];
        ball_y = pos_y[i][11:2];
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Randomized self-checking bench for ball_motion_sequencer against a frame-level reference model.
// Model honours BALL_SEQ_VCLAMP_EN the same way the design build does.
module tb_ball_motion_sequencer;

  localparam int N  = 2;
  localparam int W  = 800;
  localparam int H  = 600;
  localparam int BS = 128;
`ifdef BALL_SEQ_VCLAMP_EN
  localparam int VM = 3;
`else
  localparam int VM = 31;
`endif
  localparam int CX_M = ((W - BS) / 2) * 4;
  localparam int CY_M = ((H - BS) / 2) * 4;
  localparam int PASS_LEN = 2 * N;

  logic       clk_50mhz;
  logic       reset;
  logic       v_sync;
  logic       freeze;
  logic [2:0] sel;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       busy;
  logic       frame_done;

  int mpx [N];
  int mpy [N];
  int mvx [N];
  int mvy [N];
  int total;
  int bad;

  ball_motion_sequencer #(
    .N_BALLS(N), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .BALL_SIZE(BS), .VMAX(VM)
  ) dut (
    .clk_50mhz(clk_50mhz), .reset(reset), .v_sync(v_sync), .freeze(freeze), .sel(sel),
    .ball_x(ball_x), .ball_y(ball_y), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    clk_50mhz = 1'b0;
    forever #10 clk_50mhz = ~clk_50mhz;
  end

  // Reference model: whole-frame motion computed with plain integer arithmetic.
  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mpx[i] = ((W - BS) * (i + 1) / (N + 1)) * 4;
      mpy[i] = ((H - BS) * (N - i) / (N + 1)) * 4;
      mvx[i] = 0;
      mvy[i] = 0;
    end
  endfunction

  function automatic int step_vel(int v, int p, int c);
    int nv;
    nv = v + ((p < c) ? 1 : -1);
`ifdef BALL_SEQ_VCLAMP_EN
    if (nv > VM) nv = VM;
    if (nv < -VM) nv = -VM;
`else
    if (nv > 511) nv = nv - 1024;
    if (nv < -512) nv = nv + 1024;
`endif
    return nv;
  endfunction

  function automatic void model_frame();
    for (int b = 0; b < N; b++) begin
      mpx[b] = (mpx[b] + mvx[b]) & 4095;
      mvx[b] = step_vel(mvx[b], mpx[b], CX_M);
      mpy[b] = (mpy[b] + mvy[b]) & 4095;
      mvy[b] = step_vel(mvy[b], mpy[b], CY_M);
    end
  endfunction

  task automatic tick();
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
  endtask

  task automatic test_reset();
    logic [9:0] ex;
    logic [9:0] ey;
    reset = 1'b1; v_sync = 1'b1; freeze = 1'b0; sel = 3'd0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    model_reset();
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags busy=%b frame_done=%b expected 0 0", busy, frame_done);
    end
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      ex = (s < N) ? 10'(mpx[s] >> 2) : 10'd0;
      ey = (s < N) ? 10'(mpy[s] >> 2) : 10'd0;
      total++;
      if (ball_x !== ex || ball_y !== ey) begin
        bad++;
        $display("FAIL reset_pos sel=%0d got=(%0d,%0d) expected=(%0d,%0d)", s, ball_x, ball_y, ex, ey);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] ex;
    logic [9:0] ey;
    for (int f = 0; f < 2; f++) begin
      v_sync = 1'b0;
      for (int cyc = 1; cyc <= PASS_LEN + 2; cyc++) begin
        tick();
        if (cyc == 1) v_sync = 1'b1;
        total++;
        if (busy !== (cyc <= PASS_LEN) || frame_done !== (cyc == PASS_LEN + 1)) begin
          bad++;
          $display("FAIL frame_timing frame=%0d cyc=%0d busy=%b frame_done=%b expected %b %b",
                   f, cyc, busy, frame_done, cyc <= PASS_LEN, cyc == PASS_LEN + 1);
        end
      end
      model_frame();
      for (int s = 0; s < N; s++) begin
        sel = 3'(s);
        #1;
        ex = 10'(mpx[s] >> 2);
        ey = 10'(mpy[s] >> 2);
        total++;
        if (ball_x !== ex || ball_y !== ey) begin
          bad++;
          $display("FAIL frame_pos frame=%0d sel=%0d got=(%0d,%0d) expected=(%0d,%0d)", f, s, ball_x, ball_y, ex, ey);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int fd_count;
    logic [9:0] ex;
    logic [9:0] ey;
    fd_count = 0;
    v_sync = 1'b0;
    for (int cyc = 1; cyc <= 3 * N + 6; cyc++) begin
      tick();
      if (frame_done) fd_count++;
      if (cyc == 1 || cyc == 2 * N) v_sync = 1'b1;
      if (cyc == 2 || cyc == 2 * N + 1) v_sync = 1'b0;
      if (cyc == PASS_LEN + 2) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL dropped_edge_busy got=%b expected=0", busy);
        end
      end
    end
    v_sync = 1'b1;
    tick(); tick();
    total++;
    if (fd_count != 1) begin
      bad++;
      $display("FAIL dropped_edge_count frame_done pulses=%0d expected=1", fd_count);
    end
    model_frame();
    for (int s = 0; s < N; s++) begin
      sel = 3'(s);
      #1;
      ex = 10'(mpx[s] >> 2);
      ey = 10'(mpy[s] >> 2);
      total++;
      if (ball_x !== ex || ball_y !== ey) begin
        bad++;
        $display("FAIL dropped_edge_pos sel=%0d got=(%0d,%0d) expected=(%0d,%0d)", s, ball_x, ball_y, ex, ey);
      end
    end
  endtask

  task automatic test_freeze();
    logic [9:0] ex;
    logic [9:0] ey;
    int fd_count;
    freeze = 1'b1;
    tick();
    v_sync = 1'b0;
    for (int cyc = 1; cyc <= PASS_LEN + 3; cyc++) begin
      tick();
      if (cyc == 1) v_sync = 1'b1;
      total++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL freeze_idle cyc=%0d busy=%b frame_done=%b expected 0 0", cyc, busy, frame_done);
      end
    end
    freeze = 1'b0;
    tick();
    for (int s = 0; s < N; s++) begin
      sel = 3'(s);
      #1;
      ex = 10'(mpx[s] >> 2);
      ey = 10'(mpy[s] >> 2);
      total++;
      if (ball_x !== ex || ball_y !== ey) begin
        bad++;
        $display("FAIL freeze_pos sel=%0d got=(%0d,%0d) expected=(%0d,%0d)", s, ball_x, ball_y, ex, ey);
      end
    end
    fd_count = 0;
    v_sync = 1'b0;
    for (int cyc = 1; cyc <= PASS_LEN + 2; cyc++) begin
      tick();
      if (cyc == 1) v_sync = 1'b1;
      if (frame_done) fd_count++;
    end
    total++;
    if (fd_count != 1) begin
      bad++;
      $display("FAIL unfreeze_pass frame_done pulses=%0d expected=1", fd_count);
    end
    model_frame();
  endtask

  task automatic test_reset_midpass();
    logic [9:0] ex;
    logic [9:0] ey;
    v_sync = 1'b0;
    tick();
    v_sync = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL midpass_reset_flags busy=%b frame_done=%b expected 0 0", busy, frame_done);
    end
    for (int s = 0; s < N; s++) begin
      sel = 3'(s);
      #1;
      ex = 10'(mpx[s] >> 2);
      ey = 10'(mpy[s] >> 2);
      total++;
      if (ball_x !== ex || ball_y !== ey) begin
        bad++;
        $display("FAIL midpass_reset_pos sel=%0d got=(%0d,%0d) expected=(%0d,%0d)", s, ball_x, ball_y, ex, ey);
      end
    end
    for (int cyc = 1; cyc <= PASS_LEN + 3; cyc++) begin
      tick();
      total++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL midpass_reset_quiet cyc=%0d busy=%b frame_done=%b expected 0 0", cyc, busy, frame_done);
      end
    end
  endtask

  task automatic test_ten_frames();
    logic [9:0] ex;
    logic [9:0] ey;
    for (int f = 0; f < 10; f++) begin
      v_sync = 1'b0;
      for (int cyc = 1; cyc <= PASS_LEN + 2; cyc++) begin
        tick();
        if (cyc == 1) v_sync = 1'b1;
      end
      model_frame();
    end
    for (int s = 0; s < N; s++) begin
      sel = 3'(s);
      #1;
      ex = 10'(mpx[s] >> 2);
      ey = 10'(mpy[s] >> 2);
      total++;
      if (ball_x !== ex || ball_y !== ey) begin
        bad++;
        $display("FAIL ten_frames_pos sel=%0d got=(%0d,%0d) expected=(%0d,%0d)", s, ball_x, ball_y, ex, ey);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [9:0] ex;
    logic [9:0] ey;
    logic fz;
    int low_len;
    int fd_count;
    for (int f = 0; f < 40; f++) begin
      fz = ($urandom_range(0, 3) == 0);
      low_len = $urandom_range(1, PASS_LEN + 2);
      freeze = fz;
      v_sync = 1'b0;
      fd_count = 0;
      for (int cyc = 1; cyc <= PASS_LEN + 3; cyc++) begin
        tick();
        if (cyc == low_len) v_sync = 1'b1;
        if (cyc == 1) freeze = 1'($urandom_range(0, 1));
        if (frame_done) fd_count++;
      end
      freeze = 1'b0;
      v_sync = 1'b1;
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
      total++;
      if (fd_count != (fz ? 0 : 1)) begin
        bad++;
        $display("FAIL random_pulses frame=%0d frozen=%b got=%0d expected=%0d", f, fz, fd_count, fz ? 0 : 1);
      end
      if (!fz) model_frame();
      for (int s = 0; s < N; s++) begin
        sel = 3'(s);
        #1;
        ex = 10'(mpx[s] >> 2);
        ey = 10'(mpy[s] >> 2);
        total++;
        if (ball_x !== ex || ball_y !== ey) begin
          bad++;
          $display("FAIL random_pos frame=%0d sel=%0d got=(%0d,%0d) expected=(%0d,%0d)", f, s, ball_x, ball_y, ex, ey);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    v_sync = 1'b1;
    freeze = 1'b0;
    sel = 3'd0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_freeze();
    test_reset_midpass();
    test_ten_frames();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
